mole_generator: RTL and testbench
=================================

MOLE_GENERATOR -- requirements
Module: mole_generator

Interface
REQ-001 SHALL have parameter NUM_HOLES, default 5, number of mole positions (2..8).
REQ-002 SHALL have parameter PERIOD_INIT, default 1000, initial mole visible time in clk cycles.
REQ-003 SHALL have parameter PERIOD_MIN, default 250, floor of visible time.
REQ-004 SHALL have parameter PERIOD_STEP, default 50, visible-time decrement per hit.
REQ-005 SHALL have parameter GAP_CYCLES, default 100, blank time between moles.
REQ-006 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-008 SHALL have port game_en  in  1  level; high = game running.
REQ-009 SHALL have port guess_correct  in  1  one-cycle pulse from the scorer; current mole was hit.
REQ-010 SHALL have port mole_pos  out  3  current mole index, 0..NUM_HOLES-1.
REQ-011 SHALL have port mole_change  out  1  one-cycle pulse when mole_pos takes a new value.
REQ-012 SHALL have port mole_active  out  1  high while a mole is displayed.
REQ-013 SHALL have port mole_timeout  out  1  one-cycle pulse when a mole expires unhit.

Function
REQ-014 SHALL implement FSM states IDLE, GAP, SHOW.
REQ-015 IDLE: mole_active=0; on game_en=1 -> GAP with gap counter cleared.
REQ-016 GAP: mole_active=0; count GAP_CYCLES cycles, then load new mole_pos, pulse mole_change in the same cycle mole_pos updates, clear visible counter, -> SHOW.
REQ-017 SHOW: mole_active=1; count visible cycles up to current period.
REQ-018 SHOW with guess_correct=1 SHALL -> GAP next cycle, no mole_timeout.
REQ-019 SHOW reaching current period without a hit SHALL pulse mole_timeout for one cycle and -> GAP.
REQ-020 guess_correct and period expiry in the same cycle SHALL count as a hit; mole_timeout stays 0.
REQ-021 guess_correct in IDLE or GAP SHALL be ignored.
REQ-022 game_en=0 in any state SHALL -> IDLE next cycle; mole_active=0, mole_pos holds, no pulses.
REQ-023 New position = LFSR value mod NUM_HOLES; if equal to previous mole_pos, SHALL use (value+1) mod NUM_HOLES; consecutive moles never repeat.
REQ-024 LFSR SHALL be 8-bit maximal-length (taps 8,6,5,4), advancing every clk cycle regardless of state, never reaching zero.
REQ-025 Counters SHALL be wide enough for PERIOD_INIT and GAP_CYCLES without wrap.
REQ-026 mole_change and mole_timeout SHALL never assert in the same cycle.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, mole_pos=0, mole_change=0, mole_active=0, mole_timeout=0, counters 0, LFSR=8'hA5, period=PERIOD_INIT.
REQ-028 Reset asserted mid-SHOW or mid-GAP SHALL abort the mole with no pulse emitted.

Configuration
REQ-029 With MOLE_SPEEDUP_EN defined, each accepted hit SHALL reduce period by PERIOD_STEP, saturating at PERIOD_MIN; the new period applies from the next SHOW.
REQ-030 Without MOLE_SPEEDUP_EN, period SHALL remain PERIOD_INIT permanently.

Structure
REQ-031 Shared package whackamole_pkg SHALL hold the FSM state type, the LFSR seed constant, and default period/gap constants.
REQ-032 LFSR SHALL be the sub-module mole_lfsr (clk, rst, 8-bit value out).

Verification
REQ-033 Reset release, game_en=1 -> mole_active rises after 100 cycles, mole_change pulse same cycle, mole_pos in 0..4.
REQ-034 No hits -> mole_timeout pulse 1000 cycles after mole_change, then next mole_change 100 cycles later at a different position.
REQ-035 guess_correct at cycle 300 of SHOW -> mole_active falls next cycle, no mole_timeout; with MOLE_SPEEDUP_EN next visible time 950, after 20 hits floor 250.
REQ-036 guess_correct coincident with cycle 1000 of SHOW -> no mole_timeout; guess_correct during GAP -> no effect on timing.
REQ-037 game_en=0 mid-SHOW -> IDLE, mole_active=0, mole_pos held; rst=0 mid-GAP -> all outputs 0 immediately, mole_pos=0.
REQ-038 200 consecutive moles -> no two successive mole_pos equal, all 5 positions observed.

Source files
------------

// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole mole generator and its LFSR.
package whackamole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } mole_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    localparam int DEF_NUM_HOLES   = 5;
    localparam int DEF_PERIOD_INIT = 1000;
    localparam int DEF_PERIOD_MIN  = 250;
    localparam int DEF_PERIOD_STEP = 50;
    localparam int DEF_GAP_CYCLES  = 100;

    // Bits needed to hold 0..maxVal.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

    // Random value folded into the hole range; on a repeat of the previous
    // hole, step to the next value so consecutive moles always differ.
    function automatic logic [2:0] nextMolePos(input logic [7:0] value,
                                               input logic [2:0] prev,
                                               input int holes);
        int a;
        int b;
        a = int'(value) % holes;
        b = (int'(value) + 1) % holes;
        return (3'(a) == prev) ? 3'(b) : 3'(a);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
module mole_lfsr
    import whackamole_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    logic [7:0] r_lfsr;
    logic       w_feedback;

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Non-zero seed keeps the register out of the all-zero lock-up state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/mole_generator.sv
// Whack-a-mole mole sequencer: IDLE -> GAP -> SHOW loop with random, non-repeating holes.
// Define MOLE_SPEEDUP_EN to shorten the visible time by PERIOD_STEP on every hit.
module mole_generator
    import whackamole_pkg::*;
#(
    parameter int NUM_HOLES   = DEF_NUM_HOLES,
    parameter int PERIOD_INIT = DEF_PERIOD_INIT,
    parameter int PERIOD_MIN  = DEF_PERIOD_MIN,
    parameter int PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_en,
    input  logic       guess_correct,
    output logic [2:0] mole_pos,
    output logic       mole_change,
    output logic       mole_active,
    output logic       mole_timeout
);

    localparam int PW       = cntWidth(PERIOD_INIT);
    localparam int GW       = cntWidth(GAP_CYCLES);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    mole_state_t r_state;
    mole_state_t w_nextState;

    logic [GW-1:0] r_gapCnt;
    logic [GW-1:0] w_gapNext;
    logic [PW-1:0] r_visCnt;
    logic [PW-1:0] w_visNext;
    logic [PW-1:0] w_period;
    logic [2:0]    r_molePos;
    logic [2:0]    w_posNext;
    logic [2:0]    w_newPos;
    logic          r_moleChange;
    logic          w_changeNext;
    logic          r_moleTimeout;
    logic          w_timeoutNext;
    logic [7:0]    w_lfsr;

    mole_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (w_lfsr)
    );

    assign w_newPos = nextMolePos(w_lfsr, r_molePos, NUM_HOLES);

`ifdef MOLE_SPEEDUP_EN
    logic [PW-1:0] r_period;
    logic          w_hit;

    assign w_hit = game_en && (r_state == ST_SHOW) && guess_correct;

    // A hit ends the current SHOW, so the shortened period only matters from the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= PW'(PERIOD_INIT);
        end else if (w_hit) begin
            if (int'(r_period) >= PERIOD_MIN + PERIOD_STEP) begin
                r_period <= r_period - PW'(PERIOD_STEP);
            end else begin
                r_period <= PW'(PERIOD_MIN);
            end
        end
    end

    assign w_period = r_period;
`else
    assign w_period = PW'(PERIOD_INIT);
`endif

    // Dropping game_en overrides everything; a hit beats a same-cycle expiry.
    always_comb begin
        w_nextState   = r_state;
        w_gapNext     = r_gapCnt;
        w_visNext     = r_visCnt;
        w_posNext     = r_molePos;
        w_changeNext  = 1'b0;
        w_timeoutNext = 1'b0;
        if (!game_en) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState = ST_GAP;
                    w_gapNext   = '0;
                end
                ST_GAP: begin
                    if (r_gapCnt == GW'(GAP_LAST)) begin
                        w_nextState  = ST_SHOW;
                        w_posNext    = w_newPos;
                        w_changeNext = 1'b1;
                        w_visNext    = '0;
                    end else begin
                        w_gapNext = r_gapCnt + GW'(1);
                    end
                end
                ST_SHOW: begin
                    if (guess_correct) begin
                        w_nextState = ST_GAP;
                        w_gapNext   = '0;
                    end else if (r_visCnt == w_period - PW'(1)) begin
                        w_nextState   = ST_GAP;
                        w_gapNext     = '0;
                        w_timeoutNext = 1'b1;
                    end else begin
                        w_visNext = r_visCnt + PW'(1);
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_gapCnt      <= '0;
            r_visCnt      <= '0;
            r_molePos     <= '0;
            r_moleChange  <= 1'b0;
            r_moleTimeout <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_gapCnt      <= w_gapNext;
            r_visCnt      <= w_visNext;
            r_molePos     <= w_posNext;
            r_moleChange  <= w_changeNext;
            r_moleTimeout <= w_timeoutNext;
        end
    end

    assign mole_pos     = r_molePos;
    assign mole_change  = r_moleChange;
    assign mole_timeout = r_moleTimeout;
    assign mole_active  = (r_state == ST_SHOW);

endmodule

// File: tb/tb_mole_generator.sv
// Scoreboard bench for mole_generator; honours MOLE_SPEEDUP_EN when defined.
module tb_mole_generator;

    localparam int NH    = 5;
    localparam int PINIT = 1000;
    localparam int PMIN  = 250;
    localparam int PSTEP = 50;
    localparam int GAP   = 100;

    typedef struct {
        bit          isChange;
        int unsigned edgeNum;
        logic [2:0]  pos;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_en = 1'b0;
    logic       guess_correct = 1'b0;
    logic [2:0] mole_pos;
    logic       mole_change;
    logic       mole_active;
    logic       mole_timeout;

    int unsigned cyc;
    ev_t         expQ[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [2:0]  modelPos;
    int unsigned curPeriod;
    logic [2:0]  lastPos = 3'd0;
    logic [NH-1:0] seen = '0;

    mole_generator #(
        .NUM_HOLES   (NH),
        .PERIOD_INIT (PINIT),
        .PERIOD_MIN  (PMIN),
        .PERIOD_STEP (PSTEP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_en       (game_en),
        .guess_correct (guess_correct),
        .mole_pos      (mole_pos),
        .mole_change   (mole_change),
        .mole_active   (mole_active),
        .mole_timeout  (mole_timeout)
    );

    always #5 clk = ~clk;

    // Edge counter since reset release; edge k is the k-th rising edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic guess);
        game_en       = en;
        guess_correct = guess;
    endtask

    // Register value before edge n+1 is the seed stepped n times.
    function automatic logic [7:0] lfsrAfter(input int unsigned n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < int'(n % 255); i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic pushChange(input int unsigned k);
        int v;
        int a;
        int b;
        logic [2:0] p;
        v = int'(lfsrAfter(k - 1));
        a = v % NH;
        b = (v + 1) % NH;
        p = (3'(a) == modelPos) ? 3'(b) : 3'(a);
        expQ.push_back('{1'b1, k, p});
        modelPos = p;
    endtask

    task automatic pushTimeout(input int unsigned k);
        expQ.push_back('{1'b0, k, 3'd0});
    endtask

    task automatic hitPeriod();
`ifdef MOLE_SPEEDUP_EN
        curPeriod = (curPeriod >= PMIN + PSTEP) ? curPeriod - PSTEP : PMIN;
`endif
    endtask

    task automatic waitEdge(input int unsigned k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic pulseGuess();
        guess_correct = 1'b1;
        @(negedge clk);
        guess_correct = 1'b0;
    endtask

    // Monitor: every DUT pulse pops the next expected event and is compared against it.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            if (mole_change && mole_timeout) checkOutput("pulseExclusive", 1, 0);
            if (mole_change || mole_timeout) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedEvent: change=%0b timeout=%0b at edge %0d, expected none",
                             mole_change, mole_timeout, cyc);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventKind", {31'd0, mole_change}, {31'd0, e.isChange});
                    checkOutput("eventEdge", cyc, e.edgeNum);
                    if (e.isChange && mole_change) begin
                        checkOutput("molePos", {29'd0, mole_pos}, {29'd0, e.pos});
                        checkOutput("noRepeat", {31'd0, mole_pos == lastPos}, 0);
                        checkOutput("posRange", {31'd0, mole_pos < 3'(NH)}, 1);
                        lastPos = mole_pos;
                        if (mole_pos < 3'(NH)) seen[mole_pos] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int unsigned k;
        int unsigned kg;
        applyStimulus(1'b0, 1'b0);
        modelPos  = 3'd0;
        curPeriod = PINIT;
        repeat (3) @(negedge clk);
        checkOutput("rstPos", {29'd0, mole_pos}, 0);
        checkOutput("rstActive", {31'd0, mole_active}, 0);
        checkOutput("rstChange", {31'd0, mole_change}, 0);
        checkOutput("rstTimeout", {31'd0, mole_timeout}, 0);
        rst = 1'b1;

        // First mole, then an unhit mole timing out and the following mole.
        applyStimulus(1'b1, 1'b0);
        pushChange(GAP + 1);
        pushTimeout(GAP + 1 + curPeriod);
        pushChange(GAP + 1 + curPeriod + GAP);
        waitEdge(GAP);
        checkOutput("activeInGap", {31'd0, mole_active}, 0);
        waitEdge(GAP + 1);
        checkOutput("activeRise", {31'd0, mole_active}, 1);
        checkOutput("changeWithActive", {31'd0, mole_change}, 1);
        k = GAP + 1 + curPeriod + GAP;
        waitEdge(k);

        // Hit at SHOW cycle 300.
        waitEdge(k + 299);
        checkOutput("activeBeforeHit", {31'd0, mole_active}, 1);
        pulseGuess();
        checkOutput("activeAfterHit", {31'd0, mole_active}, 0);
        hitPeriod();
        pushChange(k + 300 + GAP);
        k = k + 300 + GAP;
        waitEdge(k);

        // Unhit mole using the (possibly shortened) period.
        pushTimeout(k + curPeriod);
        pushChange(k + curPeriod + GAP);
        k = k + curPeriod + GAP;
        waitEdge(k);

        // Hit coincident with expiry, then a stray hit during GAP.
        waitEdge(k + curPeriod - 1);
        pulseGuess();
        checkOutput("hitAtExpiryNoTimeout", {31'd0, mole_timeout}, 0);
        checkOutput("hitAtExpiryInactive", {31'd0, mole_active}, 0);
        kg = k + curPeriod;
        hitPeriod();
        waitEdge(kg + 50);
        pulseGuess();
        pushChange(kg + GAP);
        k = kg + GAP;
        waitEdge(k);

        // game_en dropped mid-SHOW, then restarted.
        waitEdge(k + 10);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("disableActive", {31'd0, mole_active}, 0);
        checkOutput("disablePosHeld", {29'd0, mole_pos}, {29'd0, modelPos});
        checkOutput("disableNoChange", {31'd0, mole_change}, 0);
        checkOutput("disableNoTimeout", {31'd0, mole_timeout}, 0);
        waitEdge(k + 20);
        applyStimulus(1'b1, 1'b0);
        pushChange(k + 21 + GAP);
        k = k + 21 + GAP;
        waitEdge(k);

        // Hit, then reset in the middle of the gap.
        pulseGuess();
        waitEdge(k + 30);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstGapPos", {29'd0, mole_pos}, 0);
        checkOutput("rstGapActive", {31'd0, mole_active}, 0);
        checkOutput("rstGapChange", {31'd0, mole_change}, 0);
        checkOutput("rstGapTimeout", {31'd0, mole_timeout}, 0);
        modelPos  = 3'd0;
        lastPos   = 3'd0;
        curPeriod = PINIT;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 200 consecutive moles, all but the last hit immediately.
        k = GAP + 1;
        for (int i = 0; i < 200; i++) begin
            pushChange(k);
            waitEdge(k);
            if (i < 199) begin
                pulseGuess();
                hitPeriod();
                k = k + 1 + GAP;
            end
        end
        pushTimeout(k + curPeriod);
        pushChange(k + curPeriod + GAP);
        waitEdge(k + curPeriod + GAP + 2);

        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        while (expQ.size() > 0) begin
            ev_t e;
            e = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL missingEvent: change=%0b expected at edge %0d, never observed", e.isChange, e.edgeNum);
        end
        checkOutput("allPositionsSeen", {{(32 - NH){1'b0}}, seen}, (32'd1 << NH) - 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
